ram32_bus_arbiter: RTL
======================

Name: ram32_bus_arbiter

Overview:
- Arbitrates the single-port RAM32 macro (32 words x 32 bits, byte write enables, 1-cycle registered read) between three requesters: host byte port (pins), SERV dbus, SERV ibus.
- Sits between the SERV Wishbone-style buses, the host pin interface and the RAM32 instance in the top level.
- Replaces the direct ack = cyc tie-off with correct read-latency-aware acks and fixed-priority grants.

Parameters:
- ADDR_W, 5, RAM word-address width (RAM depth = 2**ADDR_W words).
- CHECK_RANGE, 1, when 1, CPU accesses outside RAM are acked without touching RAM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_halt  in  1  when 1, ibus/dbus are not granted new transactions.
- host_req  in  1  host request, held until host_ack.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W+2  host byte address.
- host_wdata  in  8  host write byte.
- host_rdata  out  8  host read byte, valid while host_ack=1.
- host_ack  out  1  one-cycle host completion pulse.
- ibus_cyc  in  1  SERV instruction fetch request.
- ibus_adr  in  32  fetch byte address.
- ibus_rdt  out  32  fetch data, valid while ibus_ack=1.
- ibus_ack  out  1  one-cycle fetch completion.
- dbus_cyc  in  1  SERV data request.
- dbus_adr  in  32  data byte address.
- dbus_we  in  1  data write.
- dbus_dat  in  32  write data.
- dbus_sel  in  4  byte lane enables.
- dbus_rdt  out  32  read data, valid while dbus_ack=1.
- dbus_ack  out  1  one-cycle data completion.
- ram_en  out  1  RAM EN0.
- ram_a  out  ADDR_W  RAM A0.
- ram_we  out  4  RAM WE0.
- ram_di  out  32  RAM Di0.
- ram_do  in  32  RAM Do0.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset (rst_n=0 at posedge) -> IDLE, grant cleared, all acks 0, ram_en 0, ram_we 0. ram_we is additionally gated combinationally by rst_n, so reset during ISSUE performs no write.
- IDLE: if any eligible request, register grant by fixed priority host > dbus > ibus, then go to ISSUE. ibus/dbus are eligible only when cpu_halt=0. The grant is never preempted once taken.
- ISSUE (1 cycle): drive the granted requester's signals to RAM. Requesters hold their signals stable until ack.
  - ram_en=1.
  - ram_a = addr[ADDR_W+1:2].
  - Writes: ram_we = dbus_sel for dbus. For host, one-hot lane host_addr[1:0] and ram_di = host_wdata replicated to all 4 lanes.
  - Reads: ram_we=0. The lane index is registered for the host.
  - Next state RESP.
- RESP (1 cycle): ack=1 for the granted requester only.
  - rdt = ram_do for ibus/dbus; host_rdata = ram_do byte at the registered lane. rdt outputs are 0 when not acked.
  - ram_en=0. Next state IDLE.
- Latency: request sampled in IDLE at cycle N, ack at cycle N+2. Minimum spacing between consecutive grants is 3 cycles.
- Out-of-range access (CHECK_RANGE=1 and adr[31:ADDR_W+2] != 0 on ibus/dbus): ISSUE drives ram_en=0 and ram_we=0, RESP acks with rdt=0. Host addresses are always in range.
- Simultaneous requests: the lower-priority requester waits. It is granted at the IDLE after the winner's RESP, provided it is still requesting and eligible.
- A request that drops before grant is ignored. cpu_halt rising mid-transaction does not abort it.
- A requester that keeps cyc/req high after ack is treated as a new request.

Test Plan:
- Host write 0xA5 at byte addr 0x0D, then host read 0x0D -> host_ack two cycles after each sampled req; ram_we=4'b0010 with ram_a=3 on write; read returns host_rdata=0xA5.
- dbus write dat=0x12345678, sel=4'b1111, adr=0x10, then ibus read adr=0x10 -> ibus_rdt=0x12345678 and ibus_ack exactly one cycle, 2 cycles after request.
- host_req, dbus_cyc and ibus_cyc all asserted in the same cycle -> acks in order host, dbus, ibus at cycles N+2, N+5, N+8, each one cycle wide.
- cpu_halt=1 with ibus_cyc=1 for 10 cycles -> ibus_ack never asserts, ram_en stays 0. Deassert cpu_halt -> ibus_ack follows 2 cycles later.
- dbus write to adr=0x0000_0100 (ADDR_W=5) -> ram_en=0 and ram_we=0 throughout, dbus_ack after 2 cycles. Subsequent read of word 0 is unchanged.
- rst_n=0 asserted during a dbus write ISSUE cycle -> ram_we=0 that cycle, no ack issued, FSM back in IDLE. RAM word unchanged when read back after reset.

Source files
------------

// File: rtl/ram32_bus_arbiter.sv
// ram32_bus_arbiter: shares the single-port RAM32 macro between the host byte
// port, the SERV dbus and the SERV ibus with fixed priority host > dbus > ibus.
// Every transaction walks IDLE -> ISSUE -> RESP, so the ack lands two cycles
// after the request is sampled and lines up with the RAM's registered read data.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cpu_halt                         blocks new ibus/dbus grants
//   host_req/we/addr/wdata           host byte request (held until host_ack)
//   host_rdata, host_ack             host read byte and completion pulse
//   ibus_cyc/adr, ibus_rdt/ack       SERV instruction fetch port
//   dbus_cyc/adr/we/dat/sel          SERV data request
//   dbus_rdt, dbus_ack               SERV data response
//   ram_en/a/we/di, ram_do           RAM32 macro port 0
module ram32_bus_arbiter #(
    parameter int unsigned ADDR_W      = 5,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_halt,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W+1:0]   host_addr,
    input  logic [7:0]          host_wdata,
    output logic [7:0]          host_rdata,
    output logic                host_ack,
    input  logic                ibus_cyc,
    input  logic [31:0]         ibus_adr,
    output logic [31:0]         ibus_rdt,
    output logic                ibus_ack,
    input  logic                dbus_cyc,
    input  logic [31:0]         dbus_adr,
    input  logic                dbus_we,
    input  logic [31:0]         dbus_dat,
    input  logic [3:0]          dbus_sel,
    output logic [31:0]         dbus_rdt,
    output logic                dbus_ack,
    output logic                ram_en,
    output logic [ADDR_W-1:0]   ram_a,
    output logic [3:0]          ram_we,
    output logic [31:0]         ram_di,
    input  logic [31:0]         ram_do
);

    localparam int unsigned BYTE_ADDR_W = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_HOST, G_DBUS, G_IBUS} grant_t;

    state_t     state;
    grant_t     grant;
    logic [1:0] lane_q;
    logic       oor_q;
    logic [3:0] ram_we_q;

    logic dbus_in_range_c;
    logic ibus_in_range_c;
    logic unused_c;

    // CPU addresses above the RAM window never reach the macro.
    assign dbus_in_range_c = !CHECK_RANGE || ((dbus_adr >> BYTE_ADDR_W) == 32'd0);
    assign ibus_in_range_c = !CHECK_RANGE || ((ibus_adr >> BYTE_ADDR_W) == 32'd0);

    // Word-aligned CPU buses ignore the byte offset.
    assign unused_c = ^{dbus_adr[1:0], ibus_adr[1:0]};

    // Reset held during ISSUE must not let a write slip into the RAM.
    assign ram_we = ram_we_q & {4{rst_n}};

    // Transaction FSM; RAM controls are registered at grant and live for ISSUE only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= G_NONE;
            lane_q   <= 2'd0;
            oor_q    <= 1'b0;
            host_ack <= 1'b0;
            ibus_ack <= 1'b0;
            dbus_ack <= 1'b0;
            ram_en   <= 1'b0;
            ram_we_q <= 4'd0;
            ram_a    <= '0;
            ram_di   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_req) begin
                        grant    <= G_HOST;
                        state    <= S_ISSUE;
                        lane_q   <= host_addr[1:0];
                        oor_q    <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_a    <= host_addr[BYTE_ADDR_W-1:2];
                        ram_we_q <= host_we ? (4'b0001 << host_addr[1:0]) : 4'd0;
                        ram_di   <= {4{host_wdata}};
                    end else if (!cpu_halt && dbus_cyc) begin
                        grant    <= G_DBUS;
                        state    <= S_ISSUE;
                        oor_q    <= !dbus_in_range_c;
                        ram_en   <= dbus_in_range_c;
                        ram_a    <= dbus_adr[BYTE_ADDR_W-1:2];
                        ram_we_q <= (dbus_we && dbus_in_range_c) ? dbus_sel : 4'd0;
                        ram_di   <= dbus_dat;
                    end else if (!cpu_halt && ibus_cyc) begin
                        grant    <= G_IBUS;
                        state    <= S_ISSUE;
                        oor_q    <= !ibus_in_range_c;
                        ram_en   <= ibus_in_range_c;
                        ram_a    <= ibus_adr[BYTE_ADDR_W-1:2];
                        ram_we_q <= 4'd0;
                        ram_di   <= 32'd0;
                    end
                end
                S_ISSUE: begin
                    ram_en   <= 1'b0;
                    ram_we_q <= 4'd0;
                    host_ack <= (grant == G_HOST);
                    dbus_ack <= (grant == G_DBUS);
                    ibus_ack <= (grant == G_IBUS);
                    state    <= S_RESP;
                end
                S_RESP: begin
                    host_ack <= 1'b0;
                    dbus_ack <= 1'b0;
                    ibus_ack <= 1'b0;
                    grant    <= G_NONE;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= G_NONE;
                end
            endcase
        end
    end

    // Read data comes straight from the macro during RESP, zero otherwise.
    assign ibus_rdt = (ibus_ack && !oor_q) ? ram_do : 32'd0;
    assign dbus_rdt = (dbus_ack && !oor_q) ? ram_do : 32'd0;

    // Host byte lane picked with the offset captured at grant.
    always_comb begin
        host_rdata = 8'd0;
        if (host_ack) begin
            case (lane_q)
                2'd0:    host_rdata = ram_do[7:0];
                2'd1:    host_rdata = ram_do[15:8];
                2'd2:    host_rdata = ram_do[23:16];
                default: host_rdata = ram_do[31:24];
            endcase
        end
    end

endmodule
